// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS multicycle control unit: opcodes, FSM states,
// datapath select codes and the bundled control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_REXEC   = 4'd6,
        S_RWB     = 4'd7,
        S_ADDIEX  = 4'd8,
        S_ANDIEX  = 4'd9,
        S_IWB     = 4'd10,
        S_BEQEX   = 4'd11,
        S_JAL     = 4'd12,
        S_ILLEGAL = 4'd13
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] mem_to_reg;
        logic [1:0] reg_dstn;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       arith;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_outdec.sv
// Combinational control-word decode: current state plus mem_ready in,
// datapath control signals out.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                // IR and PC+4 only commit once the instruction word is valid
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.arith     = 1'b1;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.arith     = 1'b1;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dstn   = RDST_RT;
                ctrl.mem_to_reg = M2R_MDR;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord       = 1'b1;
                ctrl.mem_write  = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_REXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_dstn   = RDST_RD;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.arith     = 1'b1;
            end
            S_ANDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_AND;
                ctrl.arith     = 1'b0;
            end
            S_IWB: begin
                ctrl.reg_dstn   = RDST_RT;
                ctrl.mem_to_reg = M2R_ALUOUT;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.arith         = 1'b1;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JAL: begin
                ctrl.reg_dstn   = RDST_RA;
                ctrl.mem_to_reg = M2R_PC;
                ctrl.reg_write  = 1'b1;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
            S_ILLEGAL: begin
                ctrl.illegal_op = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: state register and next-state logic; the
// control word itself comes from mips_ctrl_outdec.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] Opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      RegDstn,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUop,
    output logic            Arith,
    output logic [1:0]      PCSource,
    output logic            instr_done,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_t state_q;
    state_t state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_live;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (Opcode)
                    OP_RTYPE:     state_d = S_REXEC;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_ANDI:      state_d = S_ANDIEX;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR: state_d = (Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_REXEC:  state_d = S_RWB;
            S_ADDIEX: state_d = S_IWB;
            S_ANDIEX: state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    // Reset blanks every output combinationally so a pending write is dropped at once
    assign ctrl_live = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_live.pc_write;
    assign PCWriteCond = ctrl_live.pc_write_cond;
    assign IorD        = ctrl_live.iord;
    assign MemRead     = ctrl_live.mem_read;
    assign MemWrite    = ctrl_live.mem_write;
    assign IRWrite     = ctrl_live.ir_write;
    assign MemtoReg    = ctrl_live.mem_to_reg;
    assign RegDstn     = ctrl_live.reg_dstn;
    assign RegWrite    = ctrl_live.reg_write;
    assign ALUSrcA     = ctrl_live.alu_src_a;
    assign ALUSrcB     = ctrl_live.alu_src_b;
    assign ALUop       = ctrl_live.alu_op;
    assign Arith       = ctrl_live.arith;
    assign PCSource    = ctrl_live.pc_source;
    assign instr_done  = ctrl_live.instr_done;
    assign illegal_op  = ctrl_live.illegal_op;
    assign state       = reset ? '0 : ST_W'(state_q);

endmodule
